// File: rtl/i2s_stream_tx_if.sv
// Sample-pair stream into the I2S transmitter.
//   in_l / in_r : signed left/right samples (IN_W bits)
//   in_valid    : producer has a pair on in_l/in_r
//   in_ready    : transmitter FIFO can take a pair; a pair moves when both are high
interface i2s_stream_tx_if #(
  parameter int IN_W = 18
);
  logic signed [IN_W-1:0] in_l;
  logic signed [IN_W-1:0] in_r;
  logic                   in_valid;
  logic                   in_ready;

  modport master (output in_l, output in_r, output in_valid, input in_ready);
  modport slave  (input in_l, input in_r, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_stream_tx.sv
// Parametrised I2S / left-justified audio transmitter.
// Stereo pairs are queued in a small FIFO, volume-scaled (optionally mixed to
// mono) and width-fitted when a frame starts, then shifted out MSB first.
// Ports:
//   clk          : system clock, the only clock domain
//   pll_lock     : asynchronous active-low reset
//   en           : transmitter enable; low clears everything but underrun_cnt
//   bck_div      : half bit-clock period in clk cycles, minus 1
//   volume       : 0 mute, 1 -12 dB, 2 -6 dB, 3 unity
//   in_if        : sample-pair stream (slave side)
//   hp_bck       : bit clock
//   hp_ws        : word select, 0 = left slot
//   hp_din       : serial data, changes on the falling edge of hp_bck
//   fifo_level   : number of stored pairs
//   underrun     : one-clk pulse when a frame starts with the FIFO empty
//   underrun_cnt : saturating count of underruns
module i2s_stream_tx #(
  parameter int IN_W     = 18,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 16,
  parameter int DEPTH    = 4,
  parameter int DIV_W    = 8,
  parameter int STEREO   = 1,
  parameter int FORMAT   = 1
) (
  input  logic                         clk,
  input  logic                         pll_lock,
  input  logic                         en,
  input  logic [DIV_W-1:0]             bck_div,
  input  logic [1:0]                   volume,
  i2s_stream_tx_if.slave               in_if,
  output logic                         hp_bck,
  output logic                         hp_ws,
  output logic                         hp_din,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         underrun,
  output logic [7:0]                   underrun_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH+1);
  localparam int FRAME = 2*SLOT_W;
  localparam int BCW   = $clog2(FRAME);
  localparam int WW    = (IN_W > SAMPLE_W) ? IN_W : SAMPLE_W;

  function automatic logic signed [IN_W-1:0] scale_vol(input logic signed [IN_W-1:0] x,
                                                       input logic [1:0] vol);
    case (vol)
      2'd0:    scale_vol = '0;
      2'd1:    scale_vol = x >>> 2;
      2'd2:    scale_vol = x >>> 1;
      default: scale_vol = x;
    endcase
  endfunction

  // One guard bit makes the sum exact; halving brings it back into IN_W.
  function automatic logic signed [IN_W-1:0] mono_mix(input logic signed [IN_W-1:0] a,
                                                      input logic signed [IN_W-1:0] b);
    logic signed [IN_W:0] sum;
    sum      = (IN_W+1)'(a) + (IN_W+1)'(b);
    mono_mix = sum[IN_W:1];
  endfunction

  // Keep the top SAMPLE_W bits (truncate) or left-align with zero LSBs.
  function automatic logic [SAMPLE_W-1:0] fit_width(input logic signed [IN_W-1:0] x);
    logic [WW-1:0] t;
    t         = WW'($unsigned(x)) << (WW - IN_W);
    fit_width = t[WW-1 -: SAMPLE_W];
  endfunction

  // Left-justified bit for frame position idx; unused slot tail is zero.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] l,
                                    input logic [SAMPLE_W-1:0] r,
                                    input logic [BCW-1:0]      idx);
    int                  p;
    logic [SAMPLE_W-1:0] w_sh;
    if (int'(idx) >= SLOT_W) begin
      p    = int'(idx) - SLOT_W;
      w_sh = r << p;
    end else begin
      p    = int'(idx);
      w_sh = l << p;
    end
    slot_bit = (p < SAMPLE_W) ? w_sh[SAMPLE_W-1] : 1'b0;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    sat_inc = (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic signed [IN_W-1:0] mem_l [DEPTH];
  logic signed [IN_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [DIV_W-1:0]       div_cnt;
  logic [BCW-1:0]         bit_cnt, bit_cnt_nxt;
  logic [SAMPLE_W-1:0]    hold_l, hold_r, proc_l, proc_r, new_l, new_r;
  logic signed [IN_W-1:0] vol_l, vol_r, mix;
  logic                   bck_edge, fall, frame_start, fifo_empty, push, pop, din_nxt;

  assign in_if.in_ready = pll_lock && en && (fifo_level < LW'(DEPTH));
  assign push           = in_if.in_valid && in_if.in_ready;
  assign fifo_empty     = (fifo_level == '0);
  // >= rather than == so a smaller bck_div ends the current half period at once.
  assign bck_edge       = (div_cnt >= bck_div);
  assign fall           = bck_edge && hp_bck;
  assign frame_start    = fall && (bit_cnt == BCW'(FRAME-1));
  assign pop            = frame_start && !fifo_empty;
  assign bit_cnt_nxt    = (bit_cnt == BCW'(FRAME-1)) ? '0 : bit_cnt + 1'b1;

  always_comb begin
    vol_l = scale_vol(mem_l[rd_ptr], volume);
    vol_r = scale_vol(mem_r[rd_ptr], volume);
    mix   = mono_mix(vol_l, vol_r);
    if (STEREO != 0) begin
      proc_l = fit_width(vol_l);
      proc_r = fit_width(vol_r);
    end else begin
      proc_l = fit_width(mix);
      proc_r = proc_l;
    end
    new_l = pop ? proc_l : hold_l;
    new_r = pop ? proc_r : hold_r;
    // Left-justified needs the freshly processed MSB at the frame start itself;
    // I2S lags one bit, so the old hold supplies the previous right LSB there.
    if (FORMAT == 0)
      din_nxt = frame_start ? slot_bit(new_l, new_r, '0) : slot_bit(hold_l, hold_r, bit_cnt_nxt);
    else
      din_nxt = slot_bit(hold_l, hold_r, bit_cnt);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= in_if.in_l;
      mem_r[wr_ptr] <= in_if.in_r;
    end
  end

  always_ff @(posedge clk or negedge pll_lock) begin
    if (!pll_lock) begin
      div_cnt      <= '0;
      hp_bck       <= 1'b0;
      hp_ws        <= 1'b0;
      hp_din       <= 1'b0;
      bit_cnt      <= BCW'(FRAME-1);
      hold_l       <= '0;
      hold_r       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (!en) begin
      div_cnt      <= '0;
      hp_bck       <= 1'b0;
      hp_ws        <= 1'b0;
      hp_din       <= 1'b0;
      bit_cnt      <= BCW'(FRAME-1);
      hold_l       <= '0;
      hold_r       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      underrun     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (bck_edge) begin
        div_cnt <= '0;
        hp_bck  <= ~hp_bck;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall) begin
        bit_cnt <= bit_cnt_nxt;
        hp_ws   <= (bit_cnt_nxt >= BCW'(SLOT_W));
        hp_din  <= din_nxt;
      end
      if (frame_start) begin
        hold_l <= new_l;
        hold_r <= new_r;
        if (fifo_empty) begin
          underrun     <= 1'b1;
          underrun_cnt <= sat_inc(underrun_cnt);
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

endmodule

// File: doc/i2s_stream_tx.md
Name: i2s_stream_tx

Overview:
- Parametrised I2S audio transmitter for the headphone/amplifier path. It is the successor to the fixed 16-bit, divided-clock I2S logic in the video/audio top.
- Accepts signed stereo sample pairs through a valid/ready FIFO and applies volume scaling and optional mono mix.
- Serialises the samples in left-justified or standard I2S format. All logic runs in the single clk domain, with a runtime-programmable bit-clock divider.

Parameters:
- IN_W, 18: signed input sample width.
- SAMPLE_W, 16: transmitted sample width; must be <= SLOT_W.
- SLOT_W, 16: bits per channel slot; a frame is 2*SLOT_W bck periods.
- DEPTH, 4: FIFO depth in sample pairs; must be a power of 2 and >= 2.
- DIV_W, 8: width of the bck_div port.
- STEREO, 1: 1 sends l/r independently; 0 sends the mono mix in both slots.
- FORMAT, 1: 0 is left-justified; 1 is I2S, with data delayed one bck after the ws edge.

Ports:
- clk, in, 1: system/pixel clock.
- pll_lock, in, 1: reset. Asynchronous, active-low.
- en, in, 1: transmitter enable.
- bck_div, in, DIV_W: half bck period in clk cycles, minus 1.
- volume, in, 2: 0 mute, 1 = -12 dB, 2 = -6 dB, 3 unity.
- in_l, in, IN_W: signed left sample.
- in_r, in, IN_W: signed right sample.
- in_valid, in, 1: sample pair valid.
- in_ready, out, 1: FIFO can accept a pair.
- hp_bck, out, 1: I2S bit clock.
- hp_ws, out, 1: word select; 0 = left.
- hp_din, out, 1: serial data, MSB first.
- fifo_level, out, $clog2(DEPTH+1): stored pairs.
- underrun, out, 1: one-clk pulse when a frame starts with the FIFO empty.
- underrun_cnt, out, 8: saturating underrun count.

Behaviour:
- Reset (pll_lock low, async):
  - hp_bck, hp_ws, hp_din, underrun, in_ready = 0; underrun_cnt = 0.
  - FIFO empty; div_cnt = 0; bit_cnt = 2*SLOT_W-1; held samples = 0.
- en low (synchronous, checked every clk):
  - Same clearing as reset, except underrun_cnt is held.
  - Deasserting en mid-frame aborts the frame immediately; no partial frame completes.
- in_ready = pll_lock && en && (fifo_level < DEPTH). A push happens when in_valid && in_ready.
- Divider:
  - div_cnt counts 0..bck_div.
  - When div_cnt == bck_div: div_cnt <= 0 and hp_bck toggles.
  - bck period = 2*(bck_div+1) clk. bck_div = 0 gives clk/2.
- Falling bck event (hp_bck registered 1->0):
  - bit_cnt <= bit_cnt+1, modulo 2*SLOT_W.
  - hp_ws and hp_din update on the same clk edge. The receiver samples on the rising edge.
- Frame start (bit_cnt wraps to 0):
  - If FIFO non-empty: pop the head, process it, and latch into hold_l/hold_r. Processing is combinational from the FIFO head; the latch takes 1 clk.
  - If FIFO empty: hold_l/hold_r are retransmitted; underrun pulses for 1 clk; underrun_cnt increments, saturating at 255.
  - A push on the frame-start clk into an empty FIFO is not seen by that pop; it is still an underrun.
  - Simultaneous push and pop leave fifo_level unchanged.
- Processing (applied at latch time, using the current volume):
  - Volume: v = 0, x>>>2, x>>>1, or x, for volume 0..3.
  - STEREO=0: m = (v_l + v_r) computed in IN_W+1 bits, then >>>1. Both slots carry m. No overflow is possible.
  - Width: if IN_W >= SAMPLE_W, take bits [IN_W-1 : IN_W-SAMPLE_W] (truncation, no rounding). Otherwise left-align and zero-pad the LSBs.
- Serialisation (p = bit_cnt mod SLOT_W; slot = bit_cnt >= SLOT_W):
  - hp_ws = slot.
  - FORMAT=0: hp_din = hold_slot[SAMPLE_W-1-p] when p < SAMPLE_W, else 0.
  - FORMAT=1: hp_din is the FORMAT=0 bit for index bit_cnt-1. At bit_cnt = 0 it is the last bit of the previous frame's right slot, which is retained across the reload.
- Before the first falling bck after enable: hp_ws = hp_din = 0. The first falling edge is a frame start.
- bck_div changes take effect at the next div_cnt compare. No glitch is permitted shorter than min(old, new) half periods.

Test Plan:
- Reset/idle: pll_lock low then high with en = 0 -> all outputs 0, in_ready = 0. Then en = 1 -> in_ready = 1, fifo_level = 0.
- Basic LJ frame (FORMAT=0, STEREO=1, bck_div = 3, volume = 3, in_l = 18'h12345, in_r = 18'h3FFFC) -> bck period 8 clk. Left slot 16'h48D1 MSB first with ws = 0, then right 16'hFFFF with ws = 1. Frame = 256 clk.
- I2S delay (FORMAT=1, same data) -> din lags ws by exactly one bck. First bit after reset is 0; the left MSB appears on bit_cnt = 1.
- Mono/volume (STEREO=0, volume = 2, in_l = 18'h10000, in_r = 18'h10000) -> both slots 16'h2000.
- Underrun: push 1 pair, run 3 frames -> pair sent 3 times. underrun pulses twice; underrun_cnt = 2; it saturates at 255 after 300 frames.
- Backpressure: hold in_valid = 1 with DEPTH = 4 -> in_ready drops at fifo_level = 4. It rises 1 clk after the next frame-start pop, and fifo_level never exceeds 4.
